psum_pad_scheduler: RTL and testbench

PSUM_PAD_SCHEDULER -- requirements
Module: psum_pad_scheduler

---
 rtl/psum_pad_scheduler_if.sv | 50 +++++
 rtl/psum_pad_scheduler.sv | 157 +++++++++++++++
 tb/tb_psum_pad_scheduler.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/psum_pad_scheduler_if.sv
// Bundles every control/handshake signal of the psum pad scheduler.
//   slave  : the scheduler side (takes cfg, preload, SumStage, main read, drain ack;
//            drives pad write/read ports, handshake acks/rdy and status).
//   master : the environment side (the mirror image).
// Signals:
//   i_cfg_valid/i_cfg_words   pass start and words per pass
//   Psum_in_rdy/Psum_in_ack   external preload handshake
//   i_ss_write/i_ss_waddr     SumStage writeback (never back-pressured)
//   i_main_read/i_main_raddr  pipeline psum read request
//   i_pass_done               pipeline finished the pass
//   Psum_out_rdy/Psum_out_ack drain handshake
//   o_write/o_waddr/o_wsel    pad write port (wsel 0 = SumStage, 1 = Psum_in)
//   o_read/o_raddr            pad read port
//   o_state/o_err             FSM state and sticky error
interface psum_pad_scheduler_if #(
  parameter int unsigned AWD = 3
);
  logic           i_cfg_valid;
  logic [AWD:0]   i_cfg_words;
  logic           Psum_in_rdy;
  logic           Psum_in_ack;
  logic           i_ss_write;
  logic [AWD-1:0] i_ss_waddr;
  logic           i_main_read;
  logic [AWD-1:0] i_main_raddr;
  logic           i_pass_done;
  logic           Psum_out_rdy;
  logic           Psum_out_ack;
  logic           o_write;
  logic [AWD-1:0] o_waddr;
  logic           o_wsel;
  logic           o_read;
  logic [AWD-1:0] o_raddr;
  logic [1:0]     o_state;
  logic           o_err;

  modport slave (
    input  i_cfg_valid, i_cfg_words, Psum_in_rdy, i_ss_write, i_ss_waddr,
    input  i_main_read, i_main_raddr, i_pass_done, Psum_out_ack,
    output Psum_in_ack, Psum_out_rdy, o_write, o_waddr, o_wsel, o_read, o_raddr,
    output o_state, o_err
  );

  modport master (
    output i_cfg_valid, i_cfg_words, Psum_in_rdy, i_ss_write, i_ss_waddr,
    output i_main_read, i_main_raddr, i_pass_done, Psum_out_ack,
    input  Psum_in_ack, Psum_out_rdy, o_write, o_waddr, o_wsel, o_read, o_raddr,
    input  o_state, o_err
  );
endinterface

// File: rtl/psum_pad_scheduler.sv
// Psum pad scheduler: sequences one pass of a 2^AWD-word psum pad through
// LOAD (external preload), COMPUTE (pipeline owns the pad) and DRAIN (stream out).
// Ports:
//   i_clk  clock, rising edge
//   i_rst  asynchronous active-low reset
//   bus    psum_pad_scheduler_if.slave, all handshake, pad-port and status signals
module psum_pad_scheduler #(
  parameter int unsigned PSUMDWD = 16,
  parameter int unsigned AWD     = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  psum_pad_scheduler_if.slave   bus
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StLoad    = 2'd1,
    StCompute = 2'd2,
    StDrain   = 2'd3
  } state_e;

  // Pad data itself lives outside this block; the width only has to be sane.
  if (PSUMDWD == 0) begin : g_psumdwd_zero_illegal
  end

  localparam logic [AWD:0] CntFull = {1'b1, {AWD{1'b0}}};

  state_e         r_state, w_state_nxt;
  logic [AWD-1:0] r_k, w_k_nxt;
  logic [AWD:0]   r_cnt_max, w_cnt_max_nxt;
  logic           r_out_rdy, w_out_rdy_nxt;
  logic           r_err, w_err_nxt;

  logic [AWD:0]   w_cfg_words;
  logic           w_k_last;
  logic           w_in_xfer;
  logic           w_write, w_wsel, w_read, w_in_ack;
  logic [AWD-1:0] w_waddr, w_raddr;

  // 0 means one word; anything above the pad depth is clamped so k cannot wrap.
  always_comb begin
    w_cfg_words = bus.i_cfg_words;
    if (bus.i_cfg_words == '0) begin
      w_cfg_words = (AWD+1)'(1);
    end else if (bus.i_cfg_words > CntFull) begin
      w_cfg_words = CntFull;
    end
  end

  assign w_k_last  = ({1'b0, r_k} == (r_cnt_max - 1'b1));
  // A SumStage write steals the write port, so the preload beat must wait.
  assign w_in_xfer = bus.Psum_in_rdy & ~bus.i_ss_write;

  always_comb begin
    w_state_nxt   = r_state;
    w_k_nxt       = r_k;
    w_cnt_max_nxt = r_cnt_max;
    w_out_rdy_nxt = r_out_rdy;
    w_err_nxt     = r_err;
    w_write       = 1'b0;
    w_waddr       = '0;
    w_wsel        = 1'b0;
    w_read        = 1'b0;
    w_raddr       = '0;
    w_in_ack      = 1'b0;

    if (bus.i_ss_write) begin
      w_write = 1'b1;
      w_waddr = bus.i_ss_waddr;
    end

    unique case (r_state)
      StIdle: begin
        if (bus.i_ss_write) w_err_nxt = 1'b1;
        if (bus.i_cfg_valid) begin
          w_state_nxt   = StLoad;
          w_k_nxt       = '0;
          w_cnt_max_nxt = w_cfg_words;
          w_err_nxt     = 1'b0;
        end
      end
      StLoad: begin
        w_in_ack = w_in_xfer;
        if (bus.i_ss_write && bus.Psum_in_rdy) w_err_nxt = 1'b1;
        if (w_in_xfer) begin
          w_write = 1'b1;
          w_wsel  = 1'b1;
          w_waddr = r_k;
          if (w_k_last) begin
            w_state_nxt = StCompute;
            w_k_nxt     = '0;
          end else begin
            w_k_nxt = r_k + 1'b1;
          end
        end
      end
      StCompute: begin
        w_read  = bus.i_main_read;
        w_raddr = bus.i_main_raddr;
        if (bus.i_pass_done) begin
          w_state_nxt = StDrain;
          w_k_nxt     = '0;
        end
      end
      StDrain: begin
        if (bus.i_ss_write || bus.i_main_read) w_err_nxt = 1'b1;
        if (!r_out_rdy) begin
          // First drain cycle: prime the pad read; data appears next cycle.
          w_read        = 1'b1;
          w_raddr       = '0;
          w_out_rdy_nxt = 1'b1;
        end else if (bus.Psum_out_ack) begin
          if (w_k_last) begin
            w_state_nxt   = StIdle;
            w_k_nxt       = '0;
            w_out_rdy_nxt = 1'b0;
          end else begin
            // Prefetch the next word on the transfer cycle for 1 word/cycle.
            w_read  = 1'b1;
            w_raddr = r_k + 1'b1;
            w_k_nxt = r_k + 1'b1;
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state   <= StIdle;
      r_k       <= '0;
      r_cnt_max <= (AWD+1)'(1);
      r_out_rdy <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_k       <= w_k_nxt;
      r_cnt_max <= w_cnt_max_nxt;
      r_out_rdy <= w_out_rdy_nxt;
      r_err     <= w_err_nxt;
    end
  end

  // Pass-through paths are combinational, so reset gates them to hold outputs at 0.
  assign bus.o_write      = i_rst & w_write;
  assign bus.o_waddr      = i_rst ? w_waddr : '0;
  assign bus.o_wsel       = i_rst & w_wsel;
  assign bus.o_read       = i_rst & w_read;
  assign bus.o_raddr      = i_rst ? w_raddr : '0;
  assign bus.Psum_in_ack  = i_rst & w_in_ack;
  assign bus.Psum_out_rdy = r_out_rdy;
  assign bus.o_state      = r_state;
  assign bus.o_err        = r_err;

endmodule

// File: tb/tb_psum_pad_scheduler.sv
// Randomized scoreboard bench for psum_pad_scheduler. The stimulus thread walks a
// pass-level model (load n words, compute, drain n words) and queues the pad
// writes/reads it expects; a monitor pops and compares on every DUT pad access.
module tb_psum_pad_scheduler;
  localparam int AWD   = 3;
  localparam int DEPTH = 8;
  localparam int S_IDLE = 0, S_LOAD = 1, S_COMP = 2, S_DRAIN = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  psum_pad_scheduler_if #(.AWD(AWD)) bus ();

  psum_pad_scheduler #(.PSUMDWD(16), .AWD(AWD)) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int exp_state = S_IDLE;
  int exp_err   = 0;
  int exp_wr_q[$];   // addr*2 + wsel
  int exp_rd_q[$];   // addr

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic clear_inputs();
    bus.i_cfg_valid  = 1'b0;
    bus.i_cfg_words  = '0;
    bus.Psum_in_rdy  = 1'b0;
    bus.i_ss_write   = 1'b0;
    bus.i_ss_waddr   = '0;
    bus.i_main_read  = 1'b0;
    bus.i_main_raddr = '0;
    bus.i_pass_done  = 1'b0;
    bus.Psum_out_ack = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ss_write_rand();
    int a;
    a = $urandom_range(DEPTH - 1);
    bus.i_ss_write = 1'b1;
    bus.i_ss_waddr = a[AWD-1:0];
    exp_wr_q.push_back(a * 2);
  endtask

  // Noise that must be ignored outside IDLE: cfg_valid, and pass_done outside COMPUTE.
  task automatic noise_cfg(input bit allow_done);
    int w;
    w = $urandom_range(DEPTH);
    bus.i_cfg_valid = ($urandom_range(3) == 0);
    bus.i_cfg_words = w[AWD:0];
    if (allow_done) bus.i_pass_done = ($urandom_range(3) == 0);
  endtask

  task automatic check_common(input string tag);
    check({tag, "_state"}, int'(bus.o_state), exp_state);
    check({tag, "_err"}, int'(bus.o_err), exp_err);
  endtask

  // Monitor: every pad access the DUT presents must match the next queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_write) begin
        if (exp_wr_q.size() == 0) check("unexpected_write", int'(bus.o_waddr), -1);
        else check("write_addr_sel", int'({bus.o_waddr, bus.o_wsel}), exp_wr_q.pop_front());
      end
      if (bus.o_read) begin
        if (exp_rd_q.size() == 0) check("unexpected_read", int'(bus.o_raddr), -1);
        else check("read_addr", int'(bus.o_raddr), exp_rd_q.pop_front());
      end
    end
  end

  task automatic run_pass(input int words, input int p_rdy, input int p_coll,
                          input int p_stall, input int abort_at);
    int n, k, j, a, ncomp;
    bit rdy, ss, ack, mr;
    n = (words == 0) ? 1 : ((words > DEPTH) ? DEPTH : words);

    // IDLE cycle: stray SumStage write is an error; pass_done and main_read ignored.
    clear_inputs();
    ss = ($urandom_range(99) < 30);
    if (ss) ss_write_rand();
    bus.i_pass_done = 1'b1;
    bus.i_main_read = ($urandom_range(1) == 1);
    @(negedge clk);
    check_common("idle");
    if (ss) exp_err = 1;
    tick();

    // Configure: error flag clears on entry to LOAD.
    clear_inputs();
    bus.i_cfg_valid = 1'b1;
    bus.i_cfg_words = words[AWD:0];
    @(negedge clk);
    check_common("cfg");
    exp_err = 0;
    exp_state = S_LOAD;
    tick();

    k = 0;
    while (k < n) begin
      clear_inputs();
      noise_cfg(1'b1);
      rdy = ($urandom_range(99) < p_rdy);
      ss  = ($urandom_range(99) < p_coll);
      bus.Psum_in_rdy = rdy;
      if (ss) ss_write_rand();
      else if (rdy) exp_wr_q.push_back(k * 2 + 1);
      @(negedge clk);
      check_common("load");
      check("load_in_ack", int'(bus.Psum_in_ack), int'(rdy && !ss));
      if (ss && rdy) exp_err = 1;
      if (rdy && !ss) k++;
      tick();
    end
    exp_state = S_COMP;

    ncomp = $urandom_range(4);
    for (int c = 0; c <= ncomp; c++) begin
      clear_inputs();
      noise_cfg(1'b0);
      if ($urandom_range(99) < 40) ss_write_rand();
      if ($urandom_range(99) < 50) begin
        a = $urandom_range(DEPTH - 1);
        bus.i_main_read  = 1'b1;
        bus.i_main_raddr = a[AWD-1:0];
        exp_rd_q.push_back(a);
      end
      bus.i_pass_done = (c == ncomp);
      @(negedge clk);
      check_common("comp");
      tick();
    end
    exp_state = S_DRAIN;

    // First drain cycle: read of address 0, nothing offered yet.
    clear_inputs();
    exp_rd_q.push_back(0);
    @(negedge clk);
    check_common("drain0");
    check("drain0_out_rdy", int'(bus.Psum_out_rdy), 0);
    tick();

    j = 0;
    while (j < n) begin
      clear_inputs();
      noise_cfg(1'b1);
      ack = ($urandom_range(99) >= p_stall);
      bus.Psum_out_ack = ack;
      mr = 1'b0;
      ss = 1'b0;
      if (!ack && $urandom_range(99) < 30) begin
        mr = 1'b1;
        bus.i_main_read  = 1'b1;
        bus.i_main_raddr = 3'($urandom_range(DEPTH - 1));
      end
      if (!ack && $urandom_range(99) < 20) begin
        ss = 1'b1;
        ss_write_rand();
      end
      if (ack && j < n - 1) exp_rd_q.push_back(j + 1);
      @(negedge clk);
      check_common("drain");
      check("drain_out_rdy", int'(bus.Psum_out_rdy), 1);
      if (mr || ss) exp_err = 1;
      if (ack) j++;
      tick();
      if (abort_at >= 0 && j == abort_at) begin
        clear_inputs();
        bus.i_ss_write  = 1'b1;
        bus.i_main_read = 1'b1;
        bus.Psum_in_rdy = 1'b1;
        rst_n = 1'b0;
        #1;
        check("rst_state", int'(bus.o_state), S_IDLE);
        check("rst_write", int'(bus.o_write), 0);
        check("rst_read", int'(bus.o_read), 0);
        check("rst_out_rdy", int'(bus.Psum_out_rdy), 0);
        check("rst_in_ack", int'(bus.Psum_in_ack), 0);
        check("rst_err", int'(bus.o_err), 0);
        tick();
        clear_inputs();
        rst_n = 1'b1;
        exp_state = S_IDLE;
        exp_err = 0;
        return;
      end
    end
    exp_state = S_IDLE;

    clear_inputs();
    @(negedge clk);
    check_common("post_drain");
    check("post_drain_out_rdy", int'(bus.Psum_out_rdy), 0);
    tick();
  endtask

  initial begin
    clear_inputs();
    #12;
    check("reset_state", int'(bus.o_state), S_IDLE);
    check("reset_err", int'(bus.o_err), 0);
    check("reset_out_rdy", int'(bus.Psum_out_rdy), 0);
    check("reset_write", int'(bus.o_write), 0);
    tick();
    rst_n = 1'b1;

    run_pass(4, 100, 0, 0, -1);     // clean load, back-to-back
    run_pass(3, 100, 0, 0, -1);     // drain with ack tied high
    run_pass(5, 100, 0, 80, -1);    // heavy drain back-pressure
    run_pass(8, 90, 25, 30, -1);    // full pad
    run_pass(0, 100, 50, 30, -1);   // zero words means one
    for (int i = 0; i < 25; i++) begin
      run_pass($urandom_range(DEPTH), 80, 20, 40, -1);
    end
    run_pass(4, 100, 0, 0, 1);      // reset mid-drain at k=1
    run_pass(6, 80, 20, 30, -1);    // new pass accepted after reset

    repeat (2) tick();
    check("wr_queue_empty", exp_wr_q.size(), 0);
    check("rd_queue_empty", exp_rd_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
